// File: rtl/holy_clint_pkg.sv
// Shared definitions for the CLINT-lite block: register offsets, AXI response codes
// and the byte-lane merge used by every writable register.
package holy_clint_pkg;

  localparam logic [31:0] MSIP_OFF        = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_LO_OFF = 32'h0000_4000;
  localparam logic [31:0] MTIMECMP_HI_OFF = 32'h0000_4004;
  localparam logic [31:0] MTIME_LO_OFF    = 32'h0000_BFF8;
  localparam logic [31:0] MTIME_HI_OFF    = 32'h0000_BFFC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/holy_axil_slave_if.sv
// AXI-Lite slave handshake: AW/W held independently, one-cycle write strobe, 1-cycle B and R latency.
// Backpressure: no new AW/W while B is pending, no new AR while R is pending.
module holy_axil_slave_if
  import holy_clint_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       s_axi_lite_awaddr,
  input  logic              s_axi_lite_awvalid,
  output logic              s_axi_lite_awready,
  input  logic [31:0]       s_axi_lite_wdata,
  input  logic [3:0]        s_axi_lite_wstrb,
  input  logic              s_axi_lite_wvalid,
  output logic              s_axi_lite_wready,
  output logic [1:0]        s_axi_lite_bresp,
  output logic              s_axi_lite_bvalid,
  input  logic              s_axi_lite_bready,
  input  logic [31:0]       s_axi_lite_araddr,
  input  logic              s_axi_lite_arvalid,
  output logic              s_axi_lite_arready,
  output logic [31:0]       s_axi_lite_rdata,
  output logic [1:0]        s_axi_lite_rresp,
  output logic              s_axi_lite_rvalid,
  input  logic              s_axi_lite_rready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic              rd_err
);

  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              aw_hs, w_hs;

  generate
    if (ADDR_W < 32) begin : g_upper
      logic unused_addr_bits;
      assign unused_addr_bits = ^{s_axi_lite_awaddr[31:ADDR_W], s_axi_lite_araddr[31:ADDR_W]};
    end
  endgenerate

  assign s_axi_lite_awready = !aw_held && !s_axi_lite_bvalid;
  assign s_axi_lite_wready  = !w_held && !s_axi_lite_bvalid;
  assign aw_hs = s_axi_lite_awvalid && s_axi_lite_awready;
  assign w_hs  = s_axi_lite_wvalid && s_axi_lite_wready;

  // Commit as soon as both halves are present, whether held or arriving this cycle.
  assign wr_en   = (aw_held || aw_hs) && (w_held || w_hs) && !s_axi_lite_bvalid;
  assign wr_addr = aw_held ? aw_addr_q : s_axi_lite_awaddr[ADDR_W-1:0];
  assign wr_data = w_held ? w_data_q : s_axi_lite_wdata;
  assign wr_strb = w_held ? w_strb_q : s_axi_lite_wstrb;

  assign s_axi_lite_arready = !s_axi_lite_rvalid;
  assign rd_en   = s_axi_lite_arvalid && s_axi_lite_arready;
  assign rd_addr = s_axi_lite_araddr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held           <= 1'b0;
      w_held            <= 1'b0;
      aw_addr_q         <= '0;
      w_data_q          <= '0;
      w_strb_q          <= '0;
      s_axi_lite_bvalid <= 1'b0;
      s_axi_lite_bresp  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi_lite_awaddr[ADDR_W-1:0];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi_lite_wdata;
        w_strb_q <= s_axi_lite_wstrb;
      end
      if (wr_en) begin
        s_axi_lite_bvalid <= 1'b1;
        s_axi_lite_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_lite_bvalid && s_axi_lite_bready) begin
        s_axi_lite_bvalid <= 1'b0;
        aw_held           <= 1'b0;
        w_held            <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_lite_rvalid <= 1'b0;
      s_axi_lite_rdata  <= '0;
      s_axi_lite_rresp  <= RESP_OKAY;
    end else if (rd_en) begin
      s_axi_lite_rvalid <= 1'b1;
      s_axi_lite_rdata  <= rd_data;
      s_axi_lite_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axi_lite_rvalid && s_axi_lite_rready) begin
      s_axi_lite_rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/holy_clint_lite.sv
// CLINT subset (msip, mtime, mtimecmp) behind AXI-Lite; 1-cycle B/R latency, registered timer_irq.
// Backpressure: inherited from holy_axil_slave_if (one outstanding write and one outstanding read).
module holy_clint_lite
  import holy_clint_pkg::*;
#(
  parameter int          ADDR_W       = 16,
  parameter int          TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axi_lite_awaddr,
  input  logic        s_axi_lite_awvalid,
  output logic        s_axi_lite_awready,
  input  logic [31:0] s_axi_lite_wdata,
  input  logic [3:0]  s_axi_lite_wstrb,
  input  logic        s_axi_lite_wvalid,
  output logic        s_axi_lite_wready,
  output logic [1:0]  s_axi_lite_bresp,
  output logic        s_axi_lite_bvalid,
  input  logic        s_axi_lite_bready,
  input  logic [31:0] s_axi_lite_araddr,
  input  logic        s_axi_lite_arvalid,
  output logic        s_axi_lite_arready,
  output logic [31:0] s_axi_lite_rdata,
  output logic [1:0]  s_axi_lite_rresp,
  output logic        s_axi_lite_rvalid,
  input  logic        s_axi_lite_rready,
  output logic        timer_irq,
  output logic        soft_irq
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic              wr_en, wr_err, rd_en, rd_err;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data, rd_data, wr_off, rd_off;
  logic [3:0]        wr_strb;
  logic              msip;
  logic [63:0]       mtime, mtimecmp;
  logic [PRE_W-1:0]  prescaler;
  logic              tick;

  holy_axil_slave_if #(.ADDR_W(ADDR_W)) u_axil (
    .clk, .rst_n,
    .s_axi_lite_awaddr, .s_axi_lite_awvalid, .s_axi_lite_awready,
    .s_axi_lite_wdata, .s_axi_lite_wstrb, .s_axi_lite_wvalid, .s_axi_lite_wready,
    .s_axi_lite_bresp, .s_axi_lite_bvalid, .s_axi_lite_bready,
    .s_axi_lite_araddr, .s_axi_lite_arvalid, .s_axi_lite_arready,
    .s_axi_lite_rdata, .s_axi_lite_rresp, .s_axi_lite_rvalid, .s_axi_lite_rready,
    .wr_en, .wr_addr, .wr_data, .wr_strb, .wr_err,
    .rd_en, .rd_addr, .rd_data, .rd_err
  );

  assign wr_off   = 32'(wr_addr);
  assign rd_off   = 32'(rd_addr);
  assign wr_err   = !(wr_off inside {MSIP_OFF, MTIMECMP_LO_OFF, MTIMECMP_HI_OFF,
                                     MTIME_LO_OFF, MTIME_HI_OFF});
  assign tick     = (prescaler == PRE_W'(TICK_DIV - 1));
  assign soft_irq = msip;

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_off)
      MSIP_OFF:        rd_data = {31'd0, msip};
      MTIMECMP_LO_OFF: rd_data = mtimecmp[31:0];
      MTIMECMP_HI_OFF: rd_data = mtimecmp[63:32];
      MTIME_LO_OFF:    rd_data = mtime[31:0];
      MTIME_HI_OFF:    rd_data = mtime[63:32];
      default:         rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip      <= 1'b0;
      mtime     <= '0;
      mtimecmp  <= MTIMECMP_RST;
      prescaler <= '0;
      timer_irq <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      timer_irq <= (mtime >= mtimecmp);
      if (wr_en && wr_off == MSIP_OFF && wr_strb[0]) msip <= wr_data[0];
      if (wr_en && wr_off == MTIMECMP_LO_OFF)
        mtimecmp[31:0] <= apply_wstrb(mtimecmp[31:0], wr_data, wr_strb);
      if (wr_en && wr_off == MTIMECMP_HI_OFF)
        mtimecmp[63:32] <= apply_wstrb(mtimecmp[63:32], wr_data, wr_strb);
      // A software write to either half suppresses the tick, so no carry crosses halves that cycle.
      if (wr_en && wr_off == MTIME_LO_OFF)
        mtime[31:0] <= apply_wstrb(mtime[31:0], wr_data, wr_strb);
      else if (wr_en && wr_off == MTIME_HI_OFF)
        mtime[63:32] <= apply_wstrb(mtime[63:32], wr_data, wr_strb);
      else if (tick)
        mtime <= mtime + 64'd1;
    end
  end

endmodule

// File: tb/tb_holy_clint_lite.sv
// Directed bench for holy_clint_lite: AXI-Lite register access, mtime/timer_irq timing, msip, errors, reset.
module tb_holy_clint_lite;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        timer_irq, soft_irq;

  int total = 0;
  int bad   = 0;
  int cyc;
  int commit_cyc;

  always #5 clk = ~clk;

  // Posedges since reset release; with TICK_DIV=1 mtime tracks this exactly.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  holy_clint_lite #(
    .ADDR_W(16), .TICK_DIV(1), .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
    .s_axi_lite_wready(wready), .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid),
    .s_axi_lite_bready(bready), .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid),
    .s_axi_lite_arready(arready), .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
    .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready),
    .timer_irq(timer_irq), .soft_irq(soft_irq)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the B handshake.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_done, w_done, aw_fire, w_fire;
    int n;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge clk); n++;
      if (aw_fire) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_fire)  begin wvalid = 1'b0;  w_done = 1'b1;  end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    commit_cyc = cyc;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) check_val("wr_timeout", 64'(bvalid), 64'd1);
    resp = bresp;
    bready = 1'b1; @(negedge clk); bready = 1'b0;
  endtask

  // h is the bench cycle count just after the AR handshake edge; data reflects the state before it.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int h);
    int n;
    araddr = addr; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk); arvalid = 1'b0;
    h = cyc;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) check_val("rd_timeout", 64'(rvalid), 64'd1);
    data = rdata; resp = rresp;
    rready = 1'b1; @(negedge clk); rready = 1'b0;
  endtask

  logic [31:0] d, d1;
  logic [1:0]  r;
  int          h, h1, c0, c1, n;

  initial begin
    rst_n = 1'b0; awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_bvalid", 64'(bvalid), 64'd0);
    check_val("rst_rvalid", 64'(rvalid), 64'd0);
    check_val("rst_rdata", 64'(rdata), 64'd0);
    check_val("rst_timer_irq", 64'(timer_irq), 64'd0);
    check_val("rst_soft_irq", 64'(soft_irq), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // mtime counts one per cycle from reset release
    axi_read(32'h0000_BFF8, d1, r, h1);
    check_val("mtime_lo_rd1", 64'(d1), 64'(h1 - 1));
    check_val("mtime_lo_resp1", 64'(r), 64'd0);
    axi_read(32'h0000_BFF8, d, r, h);
    check_val("mtime_lo_rd2", 64'(d), 64'(h - 1));
    check_val("mtime_increasing", 64'(d > d1), 64'd1);
    axi_read(32'h0000_BFFC, d, r, h);
    check_val("mtime_hi_zero", 64'(d), 64'd0);
    check_val("irq_idle", 64'({timer_irq, soft_irq}), 64'd0);

    // msip write with W three cycles ahead of AW
    wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
    check_val("w_ready_idle", 64'(wready), 64'd1);
    @(negedge clk); wvalid = 1'b0;
    check_val("w_held_wready", 64'(wready), 64'd0);
    repeat (2) @(negedge clk);
    check_val("no_b_without_aw", 64'(bvalid), 64'd0);
    awaddr = 32'h0; awvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0;
    check_val("b_latency_1", 64'(bvalid), 64'd1);
    check_val("msip_bresp", 64'(bresp), 64'd0);
    check_val("soft_irq_set", 64'(soft_irq), 64'd1);
    bready = 1'b1; @(negedge clk); bready = 1'b0;
    check_val("single_b", 64'(bvalid), 64'd0);
    check_val("awready_back", 64'(awready), 64'd1);
    axi_read(32'h0, d, r, h);
    check_val("msip_rd", 64'(d), 64'd1);
    axi_write(32'h0, 32'h0, 4'hF, r);
    check_val("soft_irq_clr", 64'(soft_irq), 64'd0);

    // timer_irq rises one cycle after mtime reaches 20
    axi_write(32'h0000_4004, 32'h0, 4'hF, r);
    axi_write(32'h0000_BFF8, 32'h0, 4'hF, r);
    c0 = commit_cyc;
    axi_write(32'h0000_4000, 32'd20, 4'hF, r);
    check_val("cmp_lo_bresp", 64'(r), 64'd0);
    n = 0;
    while (cyc < c0 + 20 && n < 100) begin @(negedge clk); n++; end
    check_val("irq_before_match", 64'(timer_irq), 64'd0);
    @(negedge clk);
    check_val("irq_rise", 64'(timer_irq), 64'd1);
    axi_write(32'h0000_4000, 32'hFFFF_FFFF, 4'hF, r);
    check_val("irq_fall", 64'(timer_irq), 64'd0);

    // full 64-bit wrap, then byte-lane writes
    axi_write(32'h0000_BFFC, 32'hFFFF_FFFF, 4'hF, r);
    axi_write(32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF, r);
    c1 = commit_cyc;
    axi_read(32'h0000_BFFC, d, r, h);
    check_val("wrap_hi", 64'(d), 64'd0);
    axi_read(32'h0000_BFF8, d, r, h);
    check_val("wrap_lo", 64'(d), 64'(h - c1 - 2));
    check_val("irq_after_wrap", 64'(timer_irq), 64'd0);
    axi_write(32'h0000_BFFC, 32'h0000_AB00, 4'h2, r);
    axi_read(32'h0000_BFFC, d, r, h);
    check_val("mtime_hi_strb", 64'(d), 64'h0000_AB00);
    axi_write(32'h0000_4000, 32'h0000_AB00, 4'h2, r);
    axi_read(32'h0000_4000, d, r, h);
    check_val("cmp_lo_strb", 64'(d), 64'hFFFF_ABFF);

    // unmapped and misaligned accesses
    axi_read(32'h0000_1000, d, r, h);
    check_val("unmapped_rdata", 64'(d), 64'd0);
    check_val("unmapped_rresp", 64'(r), 64'd2);
    axi_read(32'h0000_4002, d, r, h);
    check_val("misaligned_rresp", 64'(r), 64'd2);
    axi_write(32'h0000_4002, 32'h1234_5678, 4'hF, r);
    check_val("misaligned_bresp", 64'(r), 64'd2);
    axi_read(32'h0000_4000, d, r, h);
    check_val("cmp_lo_untouched", 64'(d), 64'hFFFF_ABFF);
    axi_read(32'h0000_4004, d, r, h);
    check_val("cmp_hi_untouched", 64'(d), 64'd0);
    check_val("cmp_hi_rresp", 64'(r), 64'd0);

    // B and R held under backpressure, then reset mid-hold
    awaddr = 32'h0; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h0000_4000; arvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_val("hold_bvalid", 64'(bvalid), 64'd1);
      check_val("hold_bresp", 64'(bresp), 64'd0);
      check_val("hold_rvalid", 64'(rvalid), 64'd1);
      check_val("hold_rdata", 64'(rdata), 64'hFFFF_ABFF);
      check_val("hold_readies", 64'({awready, wready, arready}), 64'd0);
      @(negedge clk);
    end
    check_val("hold_soft_irq", 64'(soft_irq), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_valids", 64'({bvalid, rvalid}), 64'd0);
    check_val("midrst_irqs", 64'({timer_irq, soft_irq}), 64'd0);
    check_val("midrst_rdata", 64'(rdata), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_val("postrst_bvalid", 64'(bvalid), 64'd0);
    check_val("postrst_readies", 64'({awready, wready, arready}), 64'h7);
    axi_read(32'h0000_4000, d, r, h);
    check_val("postrst_cmp_lo", 64'(d), 64'hFFFF_FFFF);
    axi_read(32'h0000_4004, d, r, h);
    check_val("postrst_cmp_hi", 64'(d), 64'hFFFF_FFFF);
    axi_read(32'h0, d, r, h);
    check_val("postrst_msip", 64'(d), 64'd0);
    axi_read(32'h0000_BFF8, d, r, h);
    check_val("postrst_mtime_lo", 64'(d), 64'(h - 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
